// File: rtl/camera_capture_pkg.sv
// camera_capture_pkg: constants and types shared by the camera capture path.
//   CAMERA_WIDTH / CAMERA_HEIGHT : default frame geometry (pixels / lines)
//   cap_state_t                  : capture FSM states
//   RGB565_* field positions     : layout of the assembled 16-bit pixel
package camera_capture_pkg;

    localparam int CAMERA_WIDTH  = 320;
    localparam int CAMERA_HEIGHT = 240;

    // RGB565: first camera byte lands in [15:8], second in [7:0]
    localparam int RGB565_R_MSB = 15;
    localparam int RGB565_R_LSB = 11;
    localparam int RGB565_G_MSB = 10;
    localparam int RGB565_G_LSB = 5;
    localparam int RGB565_B_MSB = 4;
    localparam int RGB565_B_LSB = 0;

    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_VBLANK = 2'd1,
        S_FRAME  = 2'd2,
        S_LINE   = 2'd3
    } cap_state_t;

endpackage

// File: rtl/camera_capture_byte_pair.sv
// camera_byte_pair: joins two consecutive camera bytes into one RGB565 word.
//   pixel_clock_in : camera pixel clock (rising edge)
//   rst_in         : asynchronous active-high reset
//   byte_en        : data_in holds a line-active byte this cycle
//   phase_clear    : drop any half-assembled pixel (line/frame boundary)
//   data_in        : camera byte bus
//   phase          : 1 when the high byte is held and the low byte is awaited
//   pair_word      : {held high byte, data_in}; meaningful when pair_strobe
//   pair_strobe    : the current byte completes a pixel
module camera_byte_pair
    import camera_capture_pkg::*;
(
    input  logic        pixel_clock_in,
    input  logic        rst_in,
    input  logic        byte_en,
    input  logic        phase_clear,
    input  logic [7:0]  data_in,
    output logic        phase,
    output logic [15:0] pair_word,
    output logic        pair_strobe
);

    logic       phase_r;
    logic [7:0] hi_r;

    // Byte phase tracking and high-byte latch
    always_ff @(posedge pixel_clock_in or posedge rst_in) begin
        if (rst_in) begin
            phase_r <= 1'b0;
            hi_r    <= 8'h00;
        end else if (phase_clear) begin
            phase_r <= 1'b0;
        end else if (byte_en) begin
            if (!phase_r) begin
                hi_r <= data_in;
            end
            phase_r <= ~phase_r;
        end
    end

    // The low byte is taken straight from the bus; the top registers the word
    assign phase       = phase_r;
    assign pair_word   = {hi_r, data_in};
    assign pair_strobe = byte_en & phase_r;

endmodule

// File: rtl/camera_capture.sv
// camera_capture: converts the raw camera bus into tagged RGB565 pixels.
//   pixel_clock_in : camera pixel clock, all logic on rising edge
//   rst_in         : asynchronous active-high reset
//   vsync_in       : high = vertical blanking
//   href_in        : high = line-active byte on data_in
//   data_in        : camera byte bus
//   frame_x_count  : column of the presented pixel (0 during blanking)
//   frame_y_count  : row of the presented pixel (0 during blanking)
//   pixel_data     : RGB565 pixel, first byte [15:8]
//   pixel_valid    : one-cycle strobe per accepted pixel
//   frame_done     : one-cycle pulse when a captured frame ends
//   line_error     : sticky, a line this frame had an odd byte count
//   overflow       : sticky, pixels/lines beyond the frame limits were dropped
module camera_capture
    import camera_capture_pkg::*;
#(
    parameter int FRAME_WIDTH  = CAMERA_WIDTH,
    parameter int FRAME_HEIGHT = CAMERA_HEIGHT
) (
    input  logic        pixel_clock_in,
    input  logic        rst_in,
    input  logic        vsync_in,
    input  logic        href_in,
    input  logic [7:0]  data_in,
    output logic [9:0]  frame_x_count,
    output logic [8:0]  frame_y_count,
    output logic [15:0] pixel_data,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic        line_error,
    output logic        overflow
);

    localparam logic [9:0] X_LIMIT = 10'(FRAME_WIDTH);
    localparam logic [8:0] Y_LIMIT = 9'(FRAME_HEIGHT);

    cap_state_t  state_r, state_next_s;

    logic        byte_en_s, line_end_s, frame_end_s, in_blank_s, flags_clear_s;
    logic        phase_clear_s, odd_drop_s, accept_s, reject_s, zero_counts_s;
    logic        phase_s, pair_strobe_s;
    logic [15:0] pair_word_s;

    logic [9:0]  x_next_r;
    logic [8:0]  y_r;
    logic        line_has_pix_r, frame_has_pix_r;

    logic [9:0]  frame_x_r;
    logic [8:0]  frame_y_r;
    logic [15:0] pixel_data_r;
    logic        pixel_valid_r, frame_done_r, line_error_r, overflow_r;

    // FSM state register
    always_ff @(posedge pixel_clock_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= S_SYNC;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; vsync always wins over href
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_SYNC:   state_next_s = vsync_in ? S_VBLANK : S_SYNC;
            S_VBLANK: state_next_s = vsync_in ? S_VBLANK : S_FRAME;
            S_FRAME:  state_next_s = vsync_in ? S_VBLANK : (href_in ? S_LINE : S_FRAME);
            S_LINE:   state_next_s = vsync_in ? S_VBLANK : (href_in ? S_LINE : S_FRAME);
            default:  state_next_s = S_SYNC;
        endcase
    end

    // FSM output decode: per-cycle control strobes for the datapath
    always_comb begin
        byte_en_s     = 1'b0;
        line_end_s    = 1'b0;
        frame_end_s   = 1'b0;
        in_blank_s    = 1'b0;
        flags_clear_s = 1'b0;
        case (state_r)
            S_SYNC: begin
                in_blank_s = 1'b1;
            end
            S_VBLANK: begin
                in_blank_s    = 1'b1;
                flags_clear_s = ~vsync_in;
            end
            S_FRAME: begin
                if (vsync_in) begin
                    frame_end_s = 1'b1;
                end else begin
                    byte_en_s = href_in;
                end
            end
            S_LINE: begin
                // vsync rising mid-line ends line and frame together
                if (vsync_in) begin
                    frame_end_s = 1'b1;
                end else if (href_in) begin
                    byte_en_s = 1'b1;
                end else begin
                    line_end_s = 1'b1;
                end
            end
            default: begin
                in_blank_s = 1'b1;
            end
        endcase
    end

    assign phase_clear_s = in_blank_s | line_end_s | frame_end_s;
    assign odd_drop_s    = (line_end_s | frame_end_s) & phase_s;
    assign accept_s      = pair_strobe_s & (x_next_r < X_LIMIT) & (y_r < Y_LIMIT);
    assign reject_s      = pair_strobe_s & ~accept_s;
    assign zero_counts_s = in_blank_s | frame_end_s;

    camera_byte_pair u_byte_pair (
        .pixel_clock_in (pixel_clock_in),
        .rst_in         (rst_in),
        .byte_en        (byte_en_s),
        .phase_clear    (phase_clear_s),
        .data_in        (data_in),
        .phase          (phase_s),
        .pair_word      (pair_word_s),
        .pair_strobe    (pair_strobe_s)
    );

    // Internal position counters; y advances only after a line that produced a pixel
    always_ff @(posedge pixel_clock_in or posedge rst_in) begin
        if (rst_in) begin
            x_next_r        <= 10'd0;
            y_r             <= 9'd0;
            line_has_pix_r  <= 1'b0;
            frame_has_pix_r <= 1'b0;
        end else if (in_blank_s) begin
            x_next_r        <= 10'd0;
            y_r             <= 9'd0;
            line_has_pix_r  <= 1'b0;
            frame_has_pix_r <= 1'b0;
        end else if (accept_s) begin
            x_next_r        <= x_next_r + 10'd1;
            line_has_pix_r  <= 1'b1;
            frame_has_pix_r <= 1'b1;
        end else if (line_end_s) begin
            x_next_r       <= 10'd0;
            line_has_pix_r <= 1'b0;
            if (line_has_pix_r) begin
                y_r <= y_r + 9'd1;
            end
        end
    end

    // Presented pixel, its coordinates and the strobes
    always_ff @(posedge pixel_clock_in or posedge rst_in) begin
        if (rst_in) begin
            pixel_valid_r <= 1'b0;
            pixel_data_r  <= 16'h0000;
            frame_x_r     <= 10'd0;
            frame_y_r     <= 9'd0;
            frame_done_r  <= 1'b0;
        end else begin
            pixel_valid_r <= accept_s;
            // an empty frame (no lines, no pixels) is not reported
            frame_done_r  <= frame_end_s & ((y_r != 9'd0) | frame_has_pix_r);
            if (accept_s) begin
                pixel_data_r <= pair_word_s;
                frame_x_r    <= x_next_r;
                frame_y_r    <= y_r;
            end else if (zero_counts_s) begin
                frame_x_r <= 10'd0;
                frame_y_r <= 9'd0;
            end
        end
    end

    // Sticky per-frame error flags, held through frame_done, cleared at vsync fall
    always_ff @(posedge pixel_clock_in or posedge rst_in) begin
        if (rst_in) begin
            line_error_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else if (flags_clear_s) begin
            line_error_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            if (odd_drop_s) begin
                line_error_r <= 1'b1;
            end
            if (reject_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign frame_x_count = frame_x_r;
    assign frame_y_count = frame_y_r;
    assign pixel_data    = pixel_data_r;
    assign pixel_valid   = pixel_valid_r;
    assign frame_done    = frame_done_r;
    assign line_error    = line_error_r;
    assign overflow      = overflow_r;

endmodule

// File: tb/tb_camera_capture.sv
// tb_camera_capture: table-driven vectors for the camera capture path plus
// hand sequences for reset, width/height limits and async reset mid-line.
module tb_camera_capture;

    logic        pixel_clock_in = 1'b0;
    logic        rst_in;
    logic        vsync_in, href_in;
    logic [7:0]  data_in;
    logic [9:0]  frame_x_count;
    logic [8:0]  frame_y_count;
    logic [15:0] pixel_data;
    logic        pixel_valid, frame_done, line_error, overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int strobe_cnt, bad_cnt, last_x, last_y;

    camera_capture dut (
        .pixel_clock_in (pixel_clock_in),
        .rst_in         (rst_in),
        .vsync_in       (vsync_in),
        .href_in        (href_in),
        .data_in        (data_in),
        .frame_x_count  (frame_x_count),
        .frame_y_count  (frame_y_count),
        .pixel_data     (pixel_data),
        .pixel_valid    (pixel_valid),
        .frame_done     (frame_done),
        .line_error     (line_error),
        .overflow       (overflow)
    );

    always #5 pixel_clock_in = ~pixel_clock_in;

    typedef struct {
        logic        v;
        logic        h;
        logic [7:0]  d;
        logic        ev;
        logic [15:0] ed;
        logic [9:0]  ex;
        logic [8:0]  ey;
        logic        edone;
        logic        elerr;
        logic        eovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic h, input logic [7:0] d,
                       input logic ev, input logic [15:0] ed,
                       input logic [9:0] ex, input logic [8:0] ey,
                       input logic edone, input logic elerr, input logic eovf);
        vec_t t;
        t.v = v; t.h = h; t.d = d;
        t.ev = ev; t.ed = ed; t.ex = ex; t.ey = ey;
        t.edone = edone; t.elerr = elerr; t.eovf = eovf;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // drive inputs, take one rising edge, sample 1 time unit later
    task automatic step(input logic v, input logic h, input logic [7:0] d);
        vsync_in = v;
        href_in  = h;
        data_in  = d;
        @(posedge pixel_clock_in);
        #1;
    endtask

    // record a strobe; by_row selects the height-sweep data/coordinate pattern
    task automatic obs(input bit by_row);
        logic [7:0]  c8;
        logic [15:0] exp_d;
        if (pixel_valid) begin
            c8    = 8'(strobe_cnt);
            exp_d = by_row ? {8'hC0, c8} : {c8, 8'h5A};
            if (by_row) begin
                if (frame_y_count !== 9'(strobe_cnt) || frame_x_count !== 10'd0 || pixel_data !== exp_d)
                    bad_cnt++;
            end else begin
                if (frame_x_count !== 10'(strobe_cnt) || frame_y_count !== 9'd0 || pixel_data !== exp_d)
                    bad_cnt++;
            end
            last_x = int'(frame_x_count);
            last_y = int'(frame_y_count);
            strobe_cnt++;
        end
    endtask

    function automatic logic [38:0] outs();
        return {pixel_valid, pixel_data, frame_x_count, frame_y_count, frame_done, line_error, overflow};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // fields: v h d | valid data x y | done lerr ovf
        add(1, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 0);
        add(0, 1, 8'h12, 0, 16'h0000, 0, 0, 0, 0, 0);
        add(0, 1, 8'h34, 1, 16'h1234, 0, 0, 0, 0, 0);
        add(0, 1, 8'h56, 0, 16'h1234, 0, 0, 0, 0, 0);
        add(0, 1, 8'h78, 1, 16'h5678, 1, 0, 0, 0, 0);
        add(0, 1, 8'h9A, 0, 16'h5678, 1, 0, 0, 0, 0);
        add(0, 1, 8'hBC, 1, 16'h9ABC, 2, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 16'h9ABC, 2, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 16'h9ABC, 2, 0, 0, 0, 0);
        add(0, 1, 8'h11, 0, 16'h9ABC, 2, 0, 0, 0, 0);
        add(0, 1, 8'h22, 1, 16'h1122, 0, 1, 0, 0, 0);
        add(0, 1, 8'h33, 0, 16'h1122, 0, 1, 0, 0, 0);
        add(0, 1, 8'h44, 1, 16'h3344, 1, 1, 0, 0, 0);
        add(0, 1, 8'h55, 0, 16'h3344, 1, 1, 0, 0, 0);
        add(0, 1, 8'h66, 1, 16'h5566, 2, 1, 0, 0, 0);
        add(0, 0, 8'h00, 0, 16'h5566, 2, 1, 0, 0, 0);
        add(1, 0, 8'h00, 0, 16'h5566, 0, 0, 1, 0, 0);   // frame end
        add(1, 0, 8'h00, 0, 16'h5566, 0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 16'h5566, 0, 0, 0, 0, 0);
        add(0, 1, 8'hA1, 0, 16'h5566, 0, 0, 0, 0, 0);   // 5-byte line
        add(0, 1, 8'hB2, 1, 16'hA1B2, 0, 0, 0, 0, 0);
        add(0, 1, 8'hC3, 0, 16'hA1B2, 0, 0, 0, 0, 0);
        add(0, 1, 8'hD4, 1, 16'hC3D4, 1, 0, 0, 0, 0);
        add(0, 1, 8'hE5, 0, 16'hC3D4, 1, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 16'hC3D4, 1, 0, 0, 1, 0);   // odd byte dropped
        add(0, 1, 8'h01, 0, 16'hC3D4, 1, 0, 0, 1, 0);
        add(0, 1, 8'h02, 1, 16'h0102, 0, 1, 0, 1, 0);
        add(0, 0, 8'h00, 0, 16'h0102, 0, 1, 0, 1, 0);
        add(1, 0, 8'h00, 0, 16'h0102, 0, 0, 1, 1, 0);
        add(1, 0, 8'h00, 0, 16'h0102, 0, 0, 0, 1, 0);
        add(0, 0, 8'h00, 0, 16'h0102, 0, 0, 0, 0, 0);   // flags clear at vsync fall
        add(0, 1, 8'hAA, 0, 16'h0102, 0, 0, 0, 0, 0);
        add(0, 1, 8'hBB, 1, 16'hAABB, 0, 0, 0, 0, 0);
        add(1, 1, 8'hCC, 0, 16'hAABB, 0, 0, 1, 0, 0);   // vsync rise mid-line
        add(1, 0, 8'h00, 0, 16'hAABB, 0, 0, 0, 0, 0);

        // reset state, then release mid-line before any vsync
        rst_in = 1'b1; vsync_in = 1'b0; href_in = 1'b0; data_in = 8'h00;
        repeat (3) @(posedge pixel_clock_in);
        #1;
        check("reset_state", {25'd0, outs()}, 64'd0);
        href_in = 1'b1; data_in = 8'h77;
        #2;
        rst_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, i[0], 8'(i + 8'h40));
            check($sformatf("no_strobe_pre_vsync%0d", i), {63'd0, pixel_valid}, 64'd0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].h, vecs[i].d);
            check($sformatf("vec%0d", i), {25'd0, outs()},
                  {25'd0, vecs[i].ev, vecs[i].ed, vecs[i].ex, vecs[i].ey,
                   vecs[i].edone, vecs[i].elerr, vecs[i].eovf});
        end

        // width limit: one line of 322 pixels
        strobe_cnt = 0; bad_cnt = 0; last_x = -1; last_y = -1;
        step(1'b0, 1'b0, 8'h00);
        for (int p = 0; p < 322; p++) begin
            step(1'b0, 1'b1, 8'(p)); obs(1'b0);
            step(1'b0, 1'b1, 8'h5A); obs(1'b0);
        end
        step(1'b0, 1'b0, 8'h00); obs(1'b0);
        step(1'b0, 1'b0, 8'h00); obs(1'b0);
        check("width_strobes", 64'(strobe_cnt), 64'd320);
        check("width_last_x", 64'(last_x), 64'd319);
        check("width_pattern_errs", 64'(bad_cnt), 64'd0);
        check("width_overflow", {63'd0, overflow}, 64'd1);
        step(1'b1, 1'b0, 8'h00);
        check("width_done_ovf", {62'd0, frame_done, overflow}, 64'd3);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check("width_ovf_cleared", {63'd0, overflow}, 64'd0);

        // height limit: 241 one-pixel lines
        strobe_cnt = 0; bad_cnt = 0; last_x = -1; last_y = -1;
        for (int l = 0; l < 241; l++) begin
            step(1'b0, 1'b1, 8'hC0);   obs(1'b1);
            step(1'b0, 1'b1, 8'(l));   obs(1'b1);
            step(1'b0, 1'b0, 8'h00);   obs(1'b1);
        end
        check("height_strobes", 64'(strobe_cnt), 64'd240);
        check("height_last_y", 64'(last_y), 64'd239);
        check("height_pattern_errs", 64'(bad_cnt), 64'd0);
        check("height_overflow", {63'd0, overflow}, 64'd1);
        step(1'b1, 1'b0, 8'h00);
        check("height_done", {63'd0, frame_done}, 64'd1);
        step(1'b1, 1'b0, 8'h00);

        // async reset mid-line
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h3C);
        step(1'b0, 1'b1, 8'h4D);
        check("pre_reset_strobe", {25'd0, outs()}, {25'd0, 1'b1, 16'h3C4D, 10'd0, 9'd0, 3'b000});
        #3;
        rst_in = 1'b1;
        #1;
        check("async_reset_outs", {25'd0, outs()}, 64'd0);
        @(posedge pixel_clock_in);
        #2;
        rst_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, ~i[0], 8'h99);
            check($sformatf("post_reset_quiet%0d", i), {62'd0, pixel_valid, frame_done}, 64'd0);
        end
        step(1'b1, 1'b0, 8'h00);
        check("no_done_from_sync", {63'd0, frame_done}, 64'd0);
        step(1'b1, 1'b0, 8'h00);
        check("no_done_vblank", {63'd0, frame_done}, 64'd0);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hE1);
        step(1'b0, 1'b1, 8'hF2);
        check("recover_strobe", {25'd0, outs()}, {25'd0, 1'b1, 16'hE1F2, 10'd0, 9'd0, 3'b000});
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check("recover_done", {63'd0, frame_done}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
